// File: rtl/traffic_light_controller_n_if.sv
// Bundle of the per-direction signals between the controller and its
// surroundings.
//   sensor     : per-direction vehicle request (level, already synchronised)
//   lights     : 3-bit lamp code per direction, bits [3i+2:3i] for direction i
//   active_dir : direction currently owning the right of way
//   phase      : 00 GREEN, 01 YELLOW, 10 ALLRED
//   tick       : one-cycle prescaler pulse
// slave  = controller side, master = board / bench side.
interface traffic_light_controller_n_if #(
  parameter int NUM_DIRS = 2
);
  localparam int DW = (NUM_DIRS > 1) ? $clog2(NUM_DIRS) : 1;

  logic [NUM_DIRS-1:0]   sensor;
  logic [3*NUM_DIRS-1:0] lights;
  logic [DW-1:0]         active_dir;
  logic [1:0]            phase;
  logic                  tick;

  modport master (
    output sensor,
    input  lights,
    input  active_dir,
    input  phase,
    input  tick
  );

  modport slave (
    input  sensor,
    output lights,
    output active_dir,
    output phase,
    output tick
  );
endinterface

// File: rtl/traffic_light_controller_n.sv
// N-direction traffic light controller with built-in tick prescaler,
// round-robin service that skips idle directions, minimum green and a
// bounded maximum green while another direction is requesting.
// Ports:
//   clock : system clock
//   reset : synchronous, active-high reset
//   tl    : slave side of traffic_light_controller_n_if
//           (sensor in; lights, active_dir, phase, tick out)
// YELLOW_TICKS and ALLRED_TICKS must not exceed MAX_GREEN_TICKS, because the
// shared dwell counter saturates at MAX_GREEN_TICKS-1.
module traffic_light_controller_n #(
  parameter int NUM_DIRS        = 2,
  parameter int TICK_DIV        = 300000000,
  parameter int GREEN_TICKS     = 2,
  parameter int MAX_GREEN_TICKS = 8,
  parameter int YELLOW_TICKS    = 1,
  parameter int ALLRED_TICKS    = 1
) (
  input  logic                          clock,
  input  logic                          reset,
  traffic_light_controller_n_if.slave   tl
);

  localparam int DW = (NUM_DIRS > 1) ? $clog2(NUM_DIRS) : 1;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int WW = (MAX_GREEN_TICKS > 1) ? $clog2(MAX_GREEN_TICKS) : 1;
  localparam int LW = 3 * NUM_DIRS;

  localparam logic [PW-1:0] TICK_LAST   = PW'(TICK_DIV - 1);
  localparam logic [WW-1:0] DWELL_SAT   = WW'(MAX_GREEN_TICKS - 1);
  localparam logic [WW-1:0] GREEN_LAST  = WW'(GREEN_TICKS - 1);
  localparam logic [WW-1:0] YELLOW_LAST = WW'(YELLOW_TICKS - 1);
  localparam logic [WW-1:0] ALLRED_LAST = WW'(ALLRED_TICKS - 1);

  localparam logic [2:0] LAMP_RED    = 3'b111;
  localparam logic [2:0] LAMP_GREEN  = 3'b011;
  localparam logic [2:0] LAMP_YELLOW = 3'b001;

  typedef enum logic [1:0] {
    PH_GREEN  = 2'b00,
    PH_YELLOW = 2'b01,
    PH_ALLRED = 2'b10
  } phase_t;

  phase_t              phase_r;
  phase_t              next_phase;
  logic [DW-1:0]       active_dir_r;
  logic [DW-1:0]       next_dir;
  logic [PW-1:0]       presc_r;
  logic [WW-1:0]       dwell_r;
  logic                tick_c;
  logic                advance;
  logic [NUM_DIRS-1:0] sensor;
  logic [NUM_DIRS-1:0] own_mask;
  logic                own_req;
  logic                other_req;
  int unsigned         cand;
  logic [2:0]          lamp;
  logic [2:0]          lamp_n;
  logic [LW-1:0]       lights_c;

  assign sensor    = tl.sensor;
  assign tick_c    = (presc_r == TICK_LAST);
  assign own_mask  = NUM_DIRS'(1) << active_dir_r;
  assign own_req   = |(sensor & own_mask);
  assign other_req = |(sensor & ~own_mask);

  // Round-robin pick: scanning offsets from NUM_DIRS down to 1 and letting
  // later hits overwrite means the smallest offset with a request wins, and
  // the current direction (offset NUM_DIRS) is only taken if nobody else asks.
  always_comb begin
    cand     = 0;
    next_dir = DW'((32'(active_dir_r) + 1) % NUM_DIRS);
    for (int unsigned i = NUM_DIRS; i >= 1; i--) begin
      cand = (32'(active_dir_r) + i) % NUM_DIRS;
      if (|(sensor & (NUM_DIRS'(1) << cand))) begin
        next_dir = DW'(cand);
      end
    end
  end

  always_comb begin
    advance    = 1'b0;
    next_phase = phase_r;
    case (phase_r)
      PH_GREEN: begin
        if (tick_c && other_req &&
            ((dwell_r >= GREEN_LAST && !own_req) || dwell_r == DWELL_SAT)) begin
          advance    = 1'b1;
          next_phase = PH_YELLOW;
        end
      end
      PH_YELLOW: begin
        if (tick_c && dwell_r == YELLOW_LAST) begin
          advance    = 1'b1;
          next_phase = PH_ALLRED;
        end
      end
      PH_ALLRED: begin
        if (tick_c && dwell_r == ALLRED_LAST) begin
          advance    = 1'b1;
          next_phase = PH_GREEN;
        end
      end
      default: begin
        advance    = 1'b1;
        next_phase = PH_GREEN;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      phase_r      <= PH_GREEN;
      active_dir_r <= '0;
      presc_r      <= '0;
      dwell_r      <= '0;
    end else begin
      presc_r <= tick_c ? '0 : presc_r + 1'b1;
      if (tick_c && dwell_r != DWELL_SAT) begin
        dwell_r <= dwell_r + 1'b1;
      end
      // A phase change restarts both counters so each phase is an exact
      // multiple of TICK_DIV cycles.
      if (advance) begin
        phase_r <= next_phase;
        presc_r <= '0;
        dwell_r <= '0;
        if (phase_r == PH_ALLRED) begin
          active_dir_r <= next_dir;
        end
      end
    end
  end

  // Only the active slot can differ from RED: place the inverted lamp code at
  // the active slot of an all-zero vector and invert the whole word.
  always_comb begin
    case (phase_r)
      PH_GREEN:  lamp = LAMP_GREEN;
      PH_YELLOW: lamp = LAMP_YELLOW;
      default:   lamp = LAMP_RED;
    endcase
    lamp_n   = ~lamp;
    lights_c = ~(LW'(lamp_n) << (32'(active_dir_r) * 3));
  end

  assign tl.lights     = lights_c;
  assign tl.active_dir = active_dir_r;
  assign tl.phase      = phase_r;
  assign tl.tick       = tick_c;

endmodule

// File: tb/tb_traffic_light_controller_n.sv
module tb_traffic_light_controller_n;

  logic clock;
  logic reset;
  logic resetb;

  traffic_light_controller_n_if #(.NUM_DIRS(3)) ifa ();
  traffic_light_controller_n_if #(.NUM_DIRS(3)) ifb ();

  traffic_light_controller_n #(
    .NUM_DIRS(3), .TICK_DIV(4), .GREEN_TICKS(2),
    .MAX_GREEN_TICKS(4), .YELLOW_TICKS(1), .ALLRED_TICKS(1)
  ) dut_a (
    .clock(clock),
    .reset(reset),
    .tl(ifa)
  );

  traffic_light_controller_n #(
    .NUM_DIRS(3), .TICK_DIV(1), .GREEN_TICKS(2),
    .MAX_GREEN_TICKS(4), .YELLOW_TICKS(1), .ALLRED_TICKS(1)
  ) dut_b (
    .clock(clock),
    .reset(resetb),
    .tl(ifb)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit         rst;     // reset before this record, restarting the cycle count
    logic [2:0] sens;    // sensor applied from this cycle on
    int         cyc;     // cycle index after the reset edge
    logic [8:0] lights;
    logic [1:0] dir;
    logic [1:0] ph;
    logic       tk;
  } vec_t;

  vec_t vecs[$];
  int   cur;

  task automatic step_a();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [1:0] exp_next(input logic [2:0] s, input logic [1:0] d);
    int unsigned k;
    k = d;
    for (int n = 0; n < 3; n++) begin
      k = (k + 1) % 3;
      if (s[k[1:0]]) return k[1:0];
    end
    return 2'((d + 1) % 3);
  endfunction

  initial begin
    logic [8:0] lb;
    logic [2:0] s;
    logic [1:0] prev_ph;
    logic [1:0] exp_ph;
    logic [1:0] exp_dir;
    logic       own;
    logic       other;
    bit         exp_valid;
    int         len;
    int         nonred;
    int         n;

    reset      = 1'b1;
    resetb     = 1'b1;
    ifa.sensor = '0;
    ifb.sensor = '0;
    cur        = 0;

    // idle: dir0 stays green, tick every 4th cycle
    vecs.push_back('{1, 3'b000,   0, 9'b111111011, 2'd0, 2'b00, 1'b0});
    vecs.push_back('{0, 3'b000,   3, 9'b111111011, 2'd0, 2'b00, 1'b1});
    vecs.push_back('{0, 3'b000,   4, 9'b111111011, 2'd0, 2'b00, 1'b0});
    vecs.push_back('{0, 3'b000,  99, 9'b111111011, 2'd0, 2'b00, 1'b1});
    vecs.push_back('{0, 3'b000, 100, 9'b111111011, 2'd0, 2'b00, 1'b0});
    // dir1 requests: min green then handover
    vecs.push_back('{1, 3'b010,   0, 9'b111111011, 2'd0, 2'b00, 1'b0});
    vecs.push_back('{0, 3'b010,   7, 9'b111111011, 2'd0, 2'b00, 1'b1});
    vecs.push_back('{0, 3'b010,   8, 9'b111111001, 2'd0, 2'b01, 1'b0});
    vecs.push_back('{0, 3'b010,  11, 9'b111111001, 2'd0, 2'b01, 1'b1});
    vecs.push_back('{0, 3'b010,  12, 9'b111111111, 2'd0, 2'b10, 1'b0});
    vecs.push_back('{0, 3'b010,  15, 9'b111111111, 2'd0, 2'b10, 1'b1});
    vecs.push_back('{0, 3'b010,  16, 9'b111011111, 2'd1, 2'b00, 1'b0});
    // both occupied: max-green cap in each direction
    vecs.push_back('{1, 3'b011,   0, 9'b111111011, 2'd0, 2'b00, 1'b0});
    vecs.push_back('{0, 3'b011,  15, 9'b111111011, 2'd0, 2'b00, 1'b1});
    vecs.push_back('{0, 3'b011,  16, 9'b111111001, 2'd0, 2'b01, 1'b0});
    vecs.push_back('{0, 3'b011,  20, 9'b111111111, 2'd0, 2'b10, 1'b0});
    vecs.push_back('{0, 3'b011,  24, 9'b111011111, 2'd1, 2'b00, 1'b0});
    vecs.push_back('{0, 3'b011,  39, 9'b111011111, 2'd1, 2'b00, 1'b1});
    vecs.push_back('{0, 3'b011,  40, 9'b111001111, 2'd1, 2'b01, 1'b0});
    vecs.push_back('{0, 3'b011,  48, 9'b111111011, 2'd0, 2'b00, 1'b0});
    // dir0 drops at cycle 10, idle dir1 skipped, dir2 served, then dir0 asks
    vecs.push_back('{1, 3'b101,   0, 9'b111111011, 2'd0, 2'b00, 1'b0});
    vecs.push_back('{0, 3'b101,   7, 9'b111111011, 2'd0, 2'b00, 1'b1});
    vecs.push_back('{0, 3'b100,  10, 9'b111111011, 2'd0, 2'b00, 1'b0});
    vecs.push_back('{0, 3'b100,  11, 9'b111111011, 2'd0, 2'b00, 1'b1});
    vecs.push_back('{0, 3'b100,  12, 9'b111111001, 2'd0, 2'b01, 1'b0});
    vecs.push_back('{0, 3'b100,  16, 9'b111111111, 2'd0, 2'b10, 1'b0});
    vecs.push_back('{0, 3'b001,  20, 9'b011111111, 2'd2, 2'b00, 1'b0});
    vecs.push_back('{0, 3'b001,  27, 9'b011111111, 2'd2, 2'b00, 1'b1});
    vecs.push_back('{0, 3'b001,  28, 9'b001111111, 2'd2, 2'b01, 1'b0});
    vecs.push_back('{0, 3'b001,  31, 9'b001111111, 2'd2, 2'b01, 1'b1});

    foreach (vecs[v]) begin
      if (vecs[v].rst) begin
        reset = 1'b1;
        step_a();
        reset = 1'b0;
        cur   = 0;
      end
      while (cur < vecs[v].cyc) begin
        step_a();
        cur++;
      end
      ifa.sensor = vecs[v].sens;
      chk($sformatf("vec%0d_lights", v), 32'(ifa.lights),     32'(vecs[v].lights));
      chk($sformatf("vec%0d_dir", v),    32'(ifa.active_dir), 32'(vecs[v].dir));
      chk($sformatf("vec%0d_phase", v),  32'(ifa.phase),      32'(vecs[v].ph));
      chk($sformatf("vec%0d_tick", v),   32'(ifa.tick),       32'(vecs[v].tk));
    end

    // reset on the yellow tick edge of dir2 must win over the transition
    reset = 1'b1;
    step_a();
    reset = 1'b0;
    ifa.sensor = 3'b010;
    chk("midrst_lights", 32'(ifa.lights),     32'h1FB);
    chk("midrst_dir",    32'(ifa.active_dir), 32'd0);
    chk("midrst_phase",  32'(ifa.phase),      32'd0);
    chk("midrst_tick",   32'(ifa.tick),       32'd0);
    n = 0;
    while (ifa.tick !== 1'b1 && n < 20) begin
      step_a();
      n++;
    end
    chk("midrst_first_tick_cycle", 32'(n), 32'd3);
    repeat (4) step_a();
    chk("midrst_green_hold", 32'(ifa.phase), 32'd0);
    step_a();
    chk("midrst_yellow_at8", 32'(ifa.phase), 32'd1);

    // randomised property run, one tick per cycle
    ifb.sensor = '0;
    step_a();
    resetb    = 1'b0;
    len       = 1;
    prev_ph   = 2'b00;
    exp_valid = 0;
    exp_ph    = 2'b00;
    exp_dir   = 2'd0;
    for (int i = 0; i < 10000; i++) begin
      lb     = ifb.lights;
      nonred = 0;
      for (int d = 0; d < 3; d++) begin
        if (lb[3*d +: 3] != 3'b111) nonred++;
      end
      chk("rnd_nonred_count", 32'(nonred), (ifb.phase == 2'b10) ? 32'd0 : 32'd1);
      if (exp_valid) begin
        chk("rnd_next_phase", 32'(ifb.phase),      32'(exp_ph));
        chk("rnd_next_dir",   32'(ifb.active_dir), 32'(exp_dir));
      end
      if (i > 0) begin
        if (ifb.phase != prev_ph) begin
          case (prev_ph)
            2'b00:   chk("rnd_green_min_len", 32'(len >= 2), 32'd1);
            2'b01:   chk("rnd_yellow_len",    32'(len),      32'd1);
            default: chk("rnd_allred_len",    32'(len),      32'd1);
          endcase
          len = 1;
        end else begin
          len++;
        end
      end
      prev_ph = ifb.phase;

      s = ($urandom_range(0, 3) == 0) ? 3'b000 : 3'($urandom_range(0, 7));
      ifb.sensor = s;
      own   = s[ifb.active_dir];
      other = |(s & ~(3'b001 << ifb.active_dir));
      exp_dir = ifb.active_dir;
      case (ifb.phase)
        2'b00:   exp_ph = (other && ((len >= 2 && !own) || len >= 4)) ? 2'b01 : 2'b00;
        2'b01:   exp_ph = 2'b10;
        default: begin
          exp_ph  = 2'b00;
          exp_dir = exp_next(s, ifb.active_dir);
        end
      endcase
      exp_valid = 1;
      step_a();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
